encrypt_function_2: RTL and testbench

Encryption stage paired with `decrypt_function_2`. Each accepted 60-bit plaintext word is masked with an 11-bit pseudo-random value from an internal LFSR, and the result is packed into the 78-bit frame that `decrypt_function_2` consumes on `data_1`. Input and output both use valid/ready handshakes, so the block sits between the plaintext source and the channel or decrypt path.

---
 rtl/enc2_pkg.sv | 24 ++
 rtl/enc2_lfsr11.sv | 26 ++
 rtl/encrypt_function_2.sv | 118 +++++++++++
 tb/tb_encrypt_function_2.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enc2_pkg.sv
// enc2_pkg: widths, FSM state encoding and mask builder shared by the encrypt stage and decrypt-side models.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package enc2_pkg;

  localparam int ENC2_PT_W    = 60;
  localparam int ENC2_RAND_W  = 11;
  localparam int ENC2_Y_W     = 61;
  localparam int ENC2_FRAME_W = 78;
  localparam int ENC2_TAG_W   = 6;

  typedef enum logic [1:0] {
    ENC2_IDLE = 2'd0,
    ENC2_CALC = 2'd1,
    ENC2_OUT  = 2'd2
  } enc2_state_e;

  // 60-bit mask: r, r, ~r, ~r, r from the LSB upward, topped with r[4:0].
  // Inverted middle fields keep the mask from being a plain repetition of r.
  function automatic logic [ENC2_PT_W-1:0] build_mask(input logic [ENC2_RAND_W-1:0] r);
    return {r[4:0], r, ~r, ~r, r, r};
  endfunction

endpackage

// File: rtl/enc2_lfsr11.sv
// enc2_lfsr11: 11-bit Fibonacci-style LFSR, steps to {r[9:0], r[10]^r[8]} when adv is high.
// Latency: new value visible the cycle after adv.
// Backpressure: none; advances only on adv. A zero SEED is replaced by 11'h001 so the register never locks up.
module enc2_lfsr11
  import enc2_pkg::*;
#(
  parameter logic [ENC2_RAND_W-1:0] SEED = 11'h5A5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   adv,
  output logic [ENC2_RAND_W-1:0] value
);

  localparam logic [ENC2_RAND_W-1:0] INIT = (SEED == '0) ? 11'h001 : SEED;

  // Shift left and feed back the tap XOR into bit 0 on each advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= INIT;
    end else if (adv) begin
      value <= {value[ENC2_RAND_W-2:0], value[10] ^ value[8]};
    end
  end

endmodule

// File: rtl/encrypt_function_2.sv
// encrypt_function_2: masks a 60-bit word plus parity with an LFSR-derived mask, emits {r, y, tag}; ENC2_SEQ_TAG_EN adds a 6-bit sequence tag.
// Latency: word accepted at edge k shows out_valid after edge k+1; one word in flight, at best one word per 3 cycles.
// Backpressure: in_ready low outside IDLE; outEnc/out_valid hold while out_ready is low.
module encrypt_function_2
  import enc2_pkg::*;
#(
  parameter logic [ENC2_RAND_W-1:0] SEED = 11'h5A5
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [ENC2_PT_W-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [ENC2_FRAME_W-1:0] outEnc,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [1:0] ST_IDLE = ENC2_IDLE;
  localparam logic [1:0] ST_CALC = ENC2_CALC;
  localparam logic [1:0] ST_OUT  = ENC2_OUT;

  logic [1:0]             state;
  logic                   accept;
  logic [ENC2_RAND_W-1:0] lfsr_val;
  logic [ENC2_TAG_W-1:0]  tag_next;

  logic [ENC2_PT_W-1:0]   pt_q;
  logic                   par_q;
  logic [ENC2_RAND_W-1:0] r_q;
  logic [ENC2_TAG_W-1:0]  tag_q;

  logic [ENC2_PT_W-1:0]   mask_c;
  logic [ENC2_Y_W-1:0]    y_c;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_ready && in_valid;

  enc2_lfsr11 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (Clk),
    .rst_n (Rst_n),
    .adv   (accept),
    .value (lfsr_val)
  );

`ifdef ENC2_SEQ_TAG_EN
  logic [ENC2_TAG_W-1:0] seq_q;

  // Sequence number of the next accepted word; wraps naturally at 63.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      seq_q <= '0;
    end else if (accept) begin
      seq_q <= seq_q + 1'b1;
    end
  end

  assign tag_next = seq_q;
`else
  assign tag_next = '0;
`endif

  // Capture the word, its parity, the current LFSR value and tag at accept.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pt_q  <= '0;
      par_q <= 1'b0;
      r_q   <= '0;
      tag_q <= '0;
    end else if (accept) begin
      pt_q  <= in_data;
      par_q <= ^in_data;
      r_q   <= lfsr_val;
      tag_q <= tag_next;
    end
  end

  // Mask and 61-bit sum; the carry out of bit 60 is intentionally dropped.
  always_comb begin
    mask_c = build_mask(r_q);
    y_c    = {pt_q, par_q} + {1'b0, mask_c};
  end

  // Control FSM: IDLE accepts, CALC registers the frame, OUT holds until taken.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      outEnc    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          outEnc    <= {r_q, y_c, tag_q};
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encrypt_function_2.sv
// tb_encrypt_function_2: directed checks of encrypt_function_2 with SEED=11'h7FF.
// Latency: expects out_valid one edge after the CALC edge following accept.
// Backpressure: exercises out_ready held low with in_valid held high.
module tb_encrypt_function_2;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [59:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [77:0] outEnc;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;
  int accepts = 0;

  logic [10:0] exp_r;
  int          exp_seq;

`ifdef ENC2_SEQ_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  always #5 Clk = ~Clk;

  encrypt_function_2 #(
    .SEED (11'h7FF)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .outEnc    (outEnc),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always @(posedge Clk) begin
    if (Rst_n && in_valid && in_ready) accepts <= accepts + 1;
  end

  // Mask built bit by bit from the field layout.
  function automatic logic [59:0] ref_mask(input logic [10:0] r);
    logic [59:0] m;
    for (int i = 0; i < 60; i++) begin
      if ((i / 11) == 2 || (i / 11) == 3) m[i] = ~r[i % 11];
      else                                 m[i] = r[i % 11];
    end
    return m;
  endfunction

  function automatic logic [10:0] ref_next(input logic [10:0] r);
    return {r[9:0], r[10] ^ r[8]};
  endfunction

  function automatic logic [60:0] ref_y(input logic [59:0] d, input logic [10:0] r);
    logic [60:0] pt;
    pt = {d, ^d};
    return pt + {1'b0, ref_mask(r)};
  endfunction

  function automatic logic [5:0] ref_tag(input int s);
    logic [5:0] t;
    t = TAG_EN ? 6'(s % 64) : 6'd0;
    return t;
  endfunction

  task automatic put_word(input logic [59:0] d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge Clk);
      if (in_ready === 1'b1) ok = 1'b1;
    end
    if (!ok) return;
    in_data  = d;
    in_valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    in_valid = 1'b0;
  endtask

  task automatic take_frame(output logic [77:0] f, output bit ok);
    ok = 1'b0;
    f  = '0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (out_valid === 1'b1) ok = 1'b1;
      else @(negedge Clk);
    end
    if (!ok) return;
    f = outEnc;
    out_ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    exp_r   = 11'h7FF;
    exp_seq = 0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    total++; if (outEnc !== 78'd0)   begin bad++; $display("FAIL reset_outEnc got %h want 0", outEnc); end
    Rst_n = 1'b1;
    exp_r = 11'h7FF; exp_seq = 0;
    @(negedge Clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL idle_after_reset got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_first_word();
    bit ok;
    logic [77:0] f;
    put_word(60'd0, ok);
    total++; if (!ok) begin bad++; $display("FAIL first_accept timeout got none want accept"); end
    // one edge after accept: CALC, nothing valid yet
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL first_calc got vld=%b rdy=%b want 0 0", out_valid, in_ready); end
    @(negedge Clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_latency got vld=%b want 1", out_valid); end
    total++; if (outEnc !== {11'h7FF, 61'hFFFF000003FFFFF, 6'd0}) begin bad++; $display("FAIL first_frame got %h want %h", outEnc, {11'h7FF, 61'hFFFF000003FFFFF, 6'd0}); end
    take_frame(f, ok);
    total++; if (!ok) begin bad++; $display("FAIL first_take timeout got none want frame"); end
    exp_r = ref_next(exp_r); exp_seq++;
  endtask

  task automatic test_wrap();
    bit ok;
    logic [77:0] f;
    logic [59:0] d;
    logic [60:0] b;
    logic [60:0] dec;
    d = 60'hFFF_FFFF_FFFF_FFFF;
    put_word(d, ok);
    take_frame(f, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_take timeout got none want frame"); end
    total++; if (f[77:67] !== 11'h7FE) begin bad++; $display("FAIL wrap_r got %h want 7fe", f[77:67]); end
    b = {1'b0, ref_mask(11'h7FE)};
    // {all ones, p=0} is 2^61-2, so the sum wraps to b-2
    total++; if (f[66:6] !== b - 61'd2) begin bad++; $display("FAIL wrap_y got %h want %h", f[66:6], b - 61'd2); end
    dec = f[66:6] - b;
    total++; if (dec[60:1] !== d || dec[0] !== 1'b0) begin bad++; $display("FAIL wrap_decrypt got %h want %h", dec, {d, 1'b0}); end
    total++; if (f[5:0] !== ref_tag(exp_seq)) begin bad++; $display("FAIL wrap_tag got %0d want %0d", f[5:0], ref_tag(exp_seq)); end
    exp_r = ref_next(exp_r); exp_seq++;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [77:0] f0;
    logic [77:0] f1;
    logic [59:0] d;
    int a0;
    d = 60'h123_4567_89AB_CDEF;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge Clk);
      if (in_ready === 1'b1) ok = 1'b1;
    end
    a0 = accepts;
    in_data = d; in_valid = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    f0 = outEnc;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got %b want 1", out_valid); end
    total++; if (f0 !== {exp_r, ref_y(d, exp_r), ref_tag(exp_seq)}) begin bad++; $display("FAIL bp_frame got %h want %h", f0, {exp_r, ref_y(d, exp_r), ref_tag(exp_seq)}); end
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      total++;
      if (outEnc !== f0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc %0d got enc=%h vld=%b rdy=%b want %h 1 0", i, outEnc, out_valid, in_ready, f0);
      end
    end
    total++; if (accepts - a0 !== 1) begin bad++; $display("FAIL bp_consumed got %0d want 1", accepts - a0); end
    exp_r = ref_next(exp_r); exp_seq++;
    out_ready = 1'b1;
    @(negedge Clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got vld=%b rdy=%b want 0 1", out_valid, in_ready); end
    @(negedge Clk);
    in_valid = 1'b0;
    total++; if (accepts - a0 !== 2) begin bad++; $display("FAIL bp_next_accept got %0d want 2", accepts - a0); end
    take_frame(f1, ok);
    total++; if (!ok || f1 !== {exp_r, ref_y(d, exp_r), ref_tag(exp_seq)}) begin bad++; $display("FAIL bp_second got %h want %h", f1, {exp_r, ref_y(d, exp_r), ref_tag(exp_seq)}); end
    exp_r = ref_next(exp_r); exp_seq++;
  endtask

  task automatic test_seq_wrap();
    bit ok;
    logic [77:0] f;
    logic [59:0] d;
    do_reset();
    for (int i = 0; i < 65; i++) begin
      d = 60'(i) * 60'h0F0_F0F0_F0F1 + 60'(i & 1);
      put_word(d, ok);
      take_frame(f, ok);
      total++; if (!ok || f[5:0] !== ref_tag(exp_seq)) begin bad++; $display("FAIL seq_tag word %0d got %0d want %0d", i, f[5:0], ref_tag(exp_seq)); end
      total++; if (f[77:6] !== {exp_r, ref_y(d, exp_r)}) begin bad++; $display("FAIL seq_body word %0d got %h want %h", i, f[77:6], {exp_r, ref_y(d, exp_r)}); end
      exp_r = ref_next(exp_r); exp_seq++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [77:0] f;
    logic [59:0] d;
    d = 60'hABC_DEF0_1234_5678;
    put_word(d, ok);
    Rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || outEnc !== 78'd0) begin bad++; $display("FAIL midrst_immediate got vld=%b rdy=%b enc=%h want 0 1 0", out_valid, in_ready, outEnc); end
    repeat (2) @(negedge Clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_hold got vld=%b want 0", out_valid); end
    Rst_n = 1'b1;
    exp_r = 11'h7FF; exp_seq = 0;
    @(negedge Clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_dropped got vld=%b want 0", out_valid); end
    put_word(d, ok);
    take_frame(f, ok);
    total++; if (!ok || f[77:67] !== 11'h7FF || f[5:0] !== 6'd0) begin bad++; $display("FAIL midrst_first got r=%h tag=%0d want 7ff 0", f[77:67], f[5:0]); end
    total++; if (f[66:6] !== ref_y(d, 11'h7FF)) begin bad++; $display("FAIL midrst_y got %h want %h", f[66:6], ref_y(d, 11'h7FF)); end
  endtask

  initial begin
    Rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    exp_r = 11'h7FF; exp_seq = 0;
    test_reset();
    test_first_word();
    test_wrap();
    test_backpressure();
    test_seq_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
